// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline controller: stall bit positions, stall vectors
// and FSM state encoding.
package pipe_ctrl_pkg;

  localparam logic RstEnable = 1'b1;
  localparam logic Stop      = 1'b1;
  localparam logic NoStop    = 1'b0;

  localparam int unsigned STALL_PC  = 0;
  localparam int unsigned STALL_IF  = 1;
  localparam int unsigned STALL_ID  = 2;
  localparam int unsigned STALL_EX  = 3;
  localparam int unsigned STALL_MEM = 4;
  localparam int unsigned STALL_WB  = 5;

  localparam logic [5:0] STALL_NONE  = 6'b000000;
  localparam logic [5:0] STALL_MEM_V = 6'b011111;
  localparam logic [5:0] STALL_EX_V  = 6'b001111;
  localparam logic [5:0] STALL_ID_V  = 6'b000111;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StBusy  = 2'b01,
    StFlush = 2'b10
  } pipe_state_e;

endpackage

// File: rtl/pipe_ctrl_mc_counter.sv
// Loadable down-counter for multi-cycle EX operations; stops at zero.
module pipe_ctrl_mc_counter
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_hold,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst == RstEnable || i_clr) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (!i_hold && r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: merges stage stall requests, sequences multi-cycle EX ops,
// issues flushes and counts stalled cycles.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MC_W   = 6,
  parameter int unsigned PERF_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stallreq_id,
  input  logic              ex_mc_start,
  input  logic [MC_W-1:0]   ex_mc_cycles,
  input  logic              stallreq_mem,
  input  logic              flush_req,
  output logic [5:0]        stall,
  output logic              exmem_bubble,
  output logic              flush,
  output logic              mc_busy,
  output logic              mc_done,
  output logic              mc_abort,
  output logic [PERF_W-1:0] stall_cycles
);

  pipe_state_e       r_state;
  logic [PERF_W-1:0] r_stall_cycles;
  logic              w_cnt_zero;
  logic              w_start;
  logic              w_in_busy;
  logic              w_ex_stall;
  logic [MC_W-1:0]   w_load_val;
  logic [5:0]        w_stall;

  assign w_in_busy  = (r_state == StBusy);
  assign w_start    = (r_state == StIdle) && ex_mc_start && !flush_req;
  // A length of 0 behaves like 1: the counter starts already at zero.
  assign w_load_val = (ex_mc_cycles == '0) ? '0 : ex_mc_cycles - 1'b1;
  assign w_ex_stall = w_start || (w_in_busy && !w_cnt_zero);

  pipe_ctrl_mc_counter #(
    .W(MC_W)
  ) u_mc_counter (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (flush_req),
    .i_load     (w_start),
    .i_load_val (w_load_val),
    .i_hold     (stallreq_mem),
    .o_zero     (w_cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      r_state <= StIdle;
    end else if (flush_req) begin
      r_state <= StFlush;
    end else begin
      unique case (r_state)
        StIdle:  if (ex_mc_start) r_state <= StBusy;
        StBusy:  if (w_cnt_zero) r_state <= StIdle;
        StFlush: r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

  always_comb begin
    w_stall = STALL_NONE;
    if (flush_req || r_state == StFlush) begin
      w_stall = STALL_NONE;
    end else if (stallreq_mem) begin
      w_stall = STALL_MEM_V;
    end else if (w_ex_stall) begin
      w_stall = STALL_EX_V;
    end else if (stallreq_id) begin
      w_stall = STALL_ID_V;
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      r_stall_cycles <= '0;
    end else if (w_stall != STALL_NONE && !(&r_stall_cycles)) begin
      r_stall_cycles <= r_stall_cycles + 1'b1;
    end
  end

  assign stall        = w_stall;
  assign exmem_bubble = w_stall[STALL_EX] & ~w_stall[STALL_MEM];
  assign flush        = (r_state == StFlush);
  assign mc_busy      = w_in_busy && !flush_req;
  assign mc_done      = w_in_busy && w_cnt_zero && !flush_req;
  assign mc_abort     = w_in_busy && flush_req;
  assign stall_cycles = r_stall_cycles;

endmodule
